// File: rtl/svm_pkg.sv
// Shared definitions for the SVM classification scheduler: scheduler state
// encoding, default geometry of the support-vector set and address sizing.
package svm_pkg;

    localparam int DEF_XLEN_PIXEL    = 8;
    localparam int DEF_NUM_OF_PIXELS = 4;
    localparam int DEF_NUM_OF_SV     = 10;
    localparam int DEF_ADDR_W        = 16;

    // Width of the pixel and support-vector index outputs.
    localparam int IDX_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_WAIT_K = 3'd2,
        ST_DECIDE = 3'd3,
        ST_WAIT_D = 3'd4,
        ST_FINISH = 3'd5
    } sched_state_t;

    // Minimum address width able to reach every word of a memory holding
    // 'depth' words; a single-word memory still needs one address bit.
    function automatic int addr_width(input int depth);
        if (depth <= 1) begin
            return 1;
        end
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/sv_addr_gen.sv
// Pixel / support-vector counter pair with read-address generation.
// The address runs as a linear counter, which always equals
// sv_idx*NUM_OF_PIXELS+pix_idx because reads are strictly sequential.
module sv_addr_gen
    import svm_pkg::*;
#(
    parameter int NUM_OF_PIXELS = DEF_NUM_OF_PIXELS,
    parameter int NUM_OF_SV     = DEF_NUM_OF_SV,
    parameter int ADDR_W        = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_read,
    input  logic              i_next_sv,
    output logic [IDX_W-1:0]  o_pix_idx,
    output logic [IDX_W-1:0]  o_sv_idx,
    output logic [ADDR_W-1:0] o_sv_addr,
    output logic              o_pix_last,
    output logic              o_sv_last
);

    localparam logic [IDX_W-1:0] PIX_LAST = IDX_W'(NUM_OF_PIXELS - 1);
    localparam logic [IDX_W-1:0] SV_LAST  = IDX_W'(NUM_OF_SV - 1);

    logic [IDX_W-1:0]  r_pix_idx;
    logic [IDX_W-1:0]  r_sv_idx;
    logic [ADDR_W-1:0] r_sv_addr;
    logic              w_pix_last;

    assign w_pix_last = (r_pix_idx == PIX_LAST);

    // Pixel counter: advances on every issued read, wraps after the last pixel.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_pix_idx <= '0;
        end else if (i_read) begin
            if (w_pix_last) begin
                r_pix_idx <= '0;
            end else begin
                r_pix_idx <= r_pix_idx + IDX_W'(1);
            end
        end
    end

    // Support-vector counter: advances only when the scheduler accepts a kernel result.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_sv_idx <= '0;
        end else if (i_next_sv) begin
            r_sv_idx <= r_sv_idx + IDX_W'(1);
        end
    end

    // Read address: one step per issued read, held while reads are paused.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_sv_addr <= '0;
        end else if (i_read) begin
            r_sv_addr <= r_sv_addr + ADDR_W'(1);
        end
    end

    assign o_pix_idx  = r_pix_idx;
    assign o_sv_idx   = r_sv_idx;
    assign o_sv_addr  = r_sv_addr;
    assign o_pix_last = w_pix_last;
    assign o_sv_last  = (r_sv_idx == SV_LAST);

endmodule

// File: rtl/sv_eval_scheduler.sv
// Scheduler for one SVM classification: streams every pixel of every support
// vector out of SV memory, hands each SV to the kernel unit, then triggers
// the decision function and reports completion.
module sv_eval_scheduler
    import svm_pkg::*;
#(
    parameter int XLEN_PIXEL    = DEF_XLEN_PIXEL,
    parameter int NUM_OF_PIXELS = DEF_NUM_OF_PIXELS,
    parameter int NUM_OF_SV     = DEF_NUM_OF_SV,
    parameter int ADDR_W        = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stall_in,
    input  logic              kernel_done,
    input  logic              decision_done,
    output logic              mem_re,
    output logic [ADDR_W-1:0] sv_addr,
    output logic [IDX_W-1:0]  pix_idx,
    output logic              kernel_en,
    output logic              kernel_last,
    output logic [IDX_W-1:0]  sv_idx,
    output logic              decision_funct_en,
    output logic              busy,
    output logic              done
);

    // Reject parameter sets the scheduler cannot address correctly.
    if (XLEN_PIXEL < 1) begin : g_bad_xlen
        $error("XLEN_PIXEL must be at least 1");
    end
    if (NUM_OF_PIXELS < 1) begin : g_bad_pixels
        $error("NUM_OF_PIXELS must be at least 1");
    end
    if (NUM_OF_SV < 1) begin : g_bad_sv
        $error("NUM_OF_SV must be at least 1");
    end
    if (ADDR_W < addr_width(NUM_OF_PIXELS * NUM_OF_SV)) begin : g_bad_addr_w
        $error("ADDR_W too narrow for NUM_OF_PIXELS*NUM_OF_SV words");
    end

    sched_state_t r_state;
    sched_state_t w_next_state;

    logic             w_clear;
    logic             w_read;
    logic             w_next_sv;
    logic             w_decision_en;
    logic             w_done;
    logic             w_pix_last;
    logic             w_sv_last;
    logic             r_kernel_en;
    logic             r_kernel_last;
    logic [IDX_W-1:0] w_pix_idx;
    logic [IDX_W-1:0] w_sv_idx;

    sv_addr_gen #(
        .NUM_OF_PIXELS (NUM_OF_PIXELS),
        .NUM_OF_SV     (NUM_OF_SV),
        .ADDR_W        (ADDR_W)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_clear),
        .i_read     (w_read),
        .i_next_sv  (w_next_sv),
        .o_pix_idx  (w_pix_idx),
        .o_sv_idx   (w_sv_idx),
        .o_sv_addr  (sv_addr),
        .o_pix_last (w_pix_last),
        .o_sv_last  (w_sv_last)
    );

    // State register; reset abandons any classification in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and control decode; kernel_done only matters in WAIT_K and start only in IDLE.
    always_comb begin
        w_next_state  = r_state;
        w_clear       = 1'b0;
        w_read        = 1'b0;
        w_next_sv     = 1'b0;
        w_decision_en = 1'b0;
        w_done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_clear = 1'b1;
                if (start) begin
                    w_next_state = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (!stall_in) begin
                    w_read = 1'b1;
                    if (w_pix_last) begin
                        w_next_state = ST_WAIT_K;
                    end
                end
            end
            ST_WAIT_K: begin
                if (kernel_done) begin
                    if (w_sv_last) begin
                        w_next_state = ST_DECIDE;
                    end else begin
                        w_next_sv    = 1'b1;
                        w_next_state = ST_FETCH;
                    end
                end
            end
            ST_DECIDE: begin
                w_decision_en = 1'b1;
                w_next_state  = ST_WAIT_D;
            end
            ST_WAIT_D: begin
                if (decision_done) begin
                    w_next_state = ST_FINISH;
                end
            end
            ST_FINISH: begin
                w_done       = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Memory data returns one cycle after the read, so the kernel strobes are the read strobes delayed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_kernel_en   <= 1'b0;
            r_kernel_last <= 1'b0;
        end else begin
            r_kernel_en   <= w_read;
            r_kernel_last <= w_read && w_pix_last;
        end
    end

    assign mem_re            = w_read;
    assign pix_idx           = w_pix_idx;
    assign sv_idx            = w_sv_idx;
    assign kernel_en         = r_kernel_en;
    assign kernel_last       = r_kernel_last;
    assign decision_funct_en = w_decision_en;
    assign done              = w_done;
    assign busy              = (r_state != ST_IDLE);

endmodule
